ahb_slave_arbiter_gen: RTL and testbench

AHB_SLAVE_ARBITER_GEN -- requirements
Module: ahb_slave_arbiter_gen

---
 rtl/ahb_slave_arbiter_gen.sv | 179 +++++++++++++++++
 tb/tb_ahb_slave_arbiter_gen.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_arbiter_gen.sv
// AHB slave-side bus arbiter: grants one of MASTER_NUM requesters ownership for a full burst.
// Latency: request-to-grant 1 cycle from idle; back-to-back handover on the edge after hlast.
// Backpressure: hwait freezes the beat counter; ownership is only released on an accepted final beat.
module ahb_slave_arbiter_gen #(
    parameter int MASTER_NUM     = 4,
    parameter int RR_MODE        = 1,
    parameter int INCR_MAX_BEATS = 16,
    parameter int MIDX_W         = $clog2(MASTER_NUM)
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic [MASTER_NUM-1:0]     hreq,
    input  logic [3*MASTER_NUM-1:0]   hburst,
    input  logic                      hwait,
    output logic [MASTER_NUM-1:0]     hgrant,
    output logic [MIDX_W-1:0]         hmaster,
    output logic                      hsel,
    output logic                      hlast
);

    localparam logic [2:0] BURST_SINGLE = 3'd0;
    localparam logic [2:0] BURST_INCR   = 3'd1;
    localparam logic [4:0] INCR_LAST    = 5'(INCR_MAX_BEATS - 1);
    localparam logic [MIDX_W-1:0] LAST_IDX = MIDX_W'(MASTER_NUM - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [MASTER_NUM-1:0]   r_grant;
    logic [MIDX_W-1:0]       r_owner;
    logic [2:0]              r_burst;
    logic [4:0]              r_cnt;
    logic [MIDX_W-1:0]       r_ptr;

    logic [2:0]              w_burst_arr [MASTER_NUM];
    logic                    w_any_req;
    logic [MIDX_W-1:0]       w_owner_inc;
    logic [MIDX_W-1:0]       w_arb_ptr;
    logic [MIDX_W-1:0]       w_winner;
    logic                    w_owned;
    logic                    w_beat_acc;
    logic                    w_is_incr;
    logic [4:0]              w_last_cnt;
    logic                    w_owner_req;
    logic                    w_last;
    logic                    w_load;

    // First asserted request at or after 'start', wrapping modulo MASTER_NUM.
    function automatic logic [MIDX_W-1:0] f_pick(
        input logic [MASTER_NUM-1:0] req,
        input logic [MIDX_W-1:0]     start
    );
        logic [MIDX_W-1:0] pick;
        logic              found;
        int                idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MASTER_NUM; k++) begin
            idx = (int'(start) + k) % MASTER_NUM;
            if (!found && req[MIDX_W'(idx)]) begin
                pick  = MIDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Count value of the final beat for a fixed-length burst type.
    function automatic logic [4:0] f_last_cnt(input logic [2:0] burst);
        logic [4:0] cnt;
        case (burst)
            3'd2, 3'd3: cnt = 5'd3;
            3'd4, 3'd5: cnt = 5'd7;
            3'd6, 3'd7: cnt = 5'd15;
            default:    cnt = 5'd0;
        endcase
        return cnt;
    endfunction

    // Unpack the per-master burst-type bus so it can be indexed by master number.
    genvar gi;
    generate
        for (gi = 0; gi < MASTER_NUM; gi++) begin : g_burst
            assign w_burst_arr[gi] = hburst[3*gi +: 3];
        end
    endgenerate

    assign w_any_req   = |hreq;
    assign w_owned     = (r_state == ST_OWNED);
    assign w_owner_inc = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

    // On a release edge the pointer is about to become owner+1, so arbitrate with that value
    // already; this makes the releasing master the lowest priority for the handover.
    assign w_arb_ptr = (RR_MODE == 0) ? '0 : (w_owned ? w_owner_inc : r_ptr);
    assign w_winner  = f_pick(hreq, w_arb_ptr);

    assign w_beat_acc  = w_owned & ~hwait;
    assign w_is_incr   = (r_burst == BURST_INCR);
    assign w_last_cnt  = f_last_cnt(r_burst);
    assign w_owner_req = hreq[r_owner];

    // Final beat: fixed bursts end on their length; INCR ends when the owner stops requesting
    // or when the beat cap is reached. Reset masks it so an aborted burst never reports done.
    assign w_last = ~hreset & w_beat_acc &
                    (w_is_incr ? (~w_owner_req | (r_cnt == INCR_LAST))
                               : (r_cnt == w_last_cnt));

    assign w_load = w_any_req & (~w_owned | w_last);

    // State register.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: enter OWNED on any request, leave only on a final beat with nobody waiting.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (w_last && !w_any_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: grant/owner come straight from registers, hlast is the combinational final-beat flag.
    always_comb begin
        hgrant  = r_grant;
        hsel    = |r_grant;
        hmaster = r_owner;
        hlast   = w_last;
    end

    // Ownership datapath: latch winner and its burst type, count accepted beats, clear on release.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_grant <= '0;
            r_owner <= '0;
            r_burst <= BURST_SINGLE;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_grant <= MASTER_NUM'(1) << w_winner;
            r_owner <= w_winner;
            r_burst <= w_burst_arr[w_winner];
            r_cnt   <= '0;
        end else if (w_last) begin
            r_grant <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
        end else if (w_beat_acc) begin
            r_cnt   <= r_cnt + 5'd1;
        end
    end

    // Round-robin pointer: moves past the owner on every release; stays at 0 in fixed mode.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_ptr <= '0;
        end else if (w_last && (RR_MODE != 0)) begin
            r_ptr <= w_owner_inc;
        end
    end

endmodule

// File: tb/tb_ahb_slave_arbiter_gen.sv
// Bench for ahb_slave_arbiter_gen: fixed-priority and round-robin instances share stimulus.
// Directed scenarios use hand-derived expectations; random traffic is checked against a burst-level model.
// Inputs change #1 after the rising edge, outputs are sampled on the falling edge.
module tb_ahb_slave_arbiter_gen;

    localparam int N   = 4;
    localparam int IMB = 16;
    localparam int MW  = $clog2(N);
    localparam int BW  = 3 * N;

    logic          hclk   = 1'b0;
    logic          hreset = 1'b1;
    logic [N-1:0]  hreq   = '0;
    logic [BW-1:0] hburst = '0;
    logic          hwait  = 1'b0;

    logic [N-1:0]  g_fx, g_rr;
    logic [MW-1:0] m_fx, m_rr;
    logic          s_fx, s_rr, l_fx, l_rr;

    always #5 hclk = ~hclk;

    ahb_slave_arbiter_gen #(.MASTER_NUM(N), .RR_MODE(0), .INCR_MAX_BEATS(IMB)) dut_fx (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .hburst(hburst), .hwait(hwait),
        .hgrant(g_fx), .hmaster(m_fx), .hsel(s_fx), .hlast(l_fx)
    );

    ahb_slave_arbiter_gen #(.MASTER_NUM(N), .RR_MODE(1), .INCR_MAX_BEATS(IMB)) dut_rr (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .hburst(hburst), .hwait(hwait),
        .hgrant(g_rr), .hmaster(m_rr), .hsel(s_rr), .hlast(l_rr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Burst-level model, index 0 = fixed priority, 1 = round-robin. owner -1 means idle.
    int           md_owner [2];
    int           md_beats [2];
    int           md_len   [2];
    bit           md_incr  [2];
    int           md_ptr   [2];
    logic [N-1:0] e_grant  [2];
    int           e_master [2];
    logic         e_sel    [2];
    logic         e_last   [2];

    function automatic int burst_len(input logic [2:0] b);
        case (b)
            3'd0:       return 1;
            3'd1:       return IMB;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    function automatic void model_outputs();
        for (int m = 0; m < 2; m++) begin
            e_grant[m]  = (md_owner[m] >= 0) ? (N'(1) << md_owner[m]) : '0;
            e_master[m] = (md_owner[m] >= 0) ? md_owner[m] : 0;
            e_sel[m]    = (md_owner[m] >= 0);
            e_last[m]   = 1'b0;
            if (md_owner[m] >= 0 && !hreset && !hwait) begin
                if (md_incr[m])
                    e_last[m] = !hreq[md_owner[m]] || (md_beats[m] == IMB - 1);
                else
                    e_last[m] = (md_beats[m] == md_len[m] - 1);
            end
        end
    endfunction

    function automatic void model_edge();
        int  start;
        int  idx;
        bit  free;
        bit  found;
        for (int m = 0; m < 2; m++) begin
            if (hreset) begin
                md_owner[m] = -1;
                md_beats[m] = 0;
                md_ptr[m]   = 0;
            end else begin
                free = (md_owner[m] < 0) || e_last[m];
                if (md_owner[m] >= 0 && !hwait) md_beats[m]++;
                if (md_owner[m] >= 0 && e_last[m]) md_ptr[m] = (md_owner[m] + 1) % N;
                if (free) begin
                    md_owner[m] = -1;
                    start = (m == 1) ? md_ptr[m] : 0;
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        idx = (start + k) % N;
                        if (!found && hreq[idx]) begin
                            found       = 1;
                            md_owner[m] = idx;
                            md_beats[m] = 0;
                            md_len[m]   = burst_len(hburst[3*idx +: 3]);
                            md_incr[m]  = (hburst[3*idx +: 3] == 3'd1);
                        end
                    end
                end
            end
        end
    endfunction

    // Advance DUTs and model by one rising edge.
    task automatic tick();
        @(posedge hclk);
        model_outputs();
        model_edge();
        #1;
    endtask

    task automatic idle_reset();
        hreset = 1'b1;
        hreq   = '0;
        hwait  = 1'b0;
        tick();
        hreset = 1'b0;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        hreq   = '0;
        hburst = '0;
        hwait  = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            hreq   = N'($urandom);
            hwait  = 1'($urandom);
            hburst = BW'($urandom);
            @(negedge hclk);
            n_cmp++;
            if (g_rr !== '0 || s_rr !== 1'b0 || m_rr !== '0 || l_rr !== 1'b0 ||
                g_fx !== '0 || s_fx !== 1'b0 || m_fx !== '0 || l_fx !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state i=%0d got rr g=%b s=%b m=%0d l=%b fx g=%b s=%b m=%0d l=%b, want all zero",
                         i, g_rr, s_rr, m_rr, l_rr, g_fx, s_fx, m_fx, l_fx);
            end
            tick();
        end
        hreset = 1'b0;
        hreq   = 4'b0010;
        hburst = '0;
        hwait  = 1'b0;
        @(negedge hclk);
        n_cmp++;
        if (g_rr !== '0 || g_fx !== '0) begin
            n_bad++;
            $display("FAIL grant_too_early got rr=%b fx=%b want 0000", g_rr, g_fx);
        end
        tick();
        @(negedge hclk);
        n_cmp++;
        if (g_rr !== 4'b0010 || g_fx !== 4'b0010 || m_rr !== MW'(1) || m_fx !== MW'(1)) begin
            n_bad++;
            $display("FAIL first_grant got rr=%b/%0d fx=%b/%0d want 0010/1", g_rr, m_rr, g_fx, m_fx);
        end
        hreq = '0;
        tick();
    endtask

    task automatic test_rr_singles();
        idle_reset();
        hreq   = '1;
        hburst = '0;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge hclk);
            n_cmp++;
            if (m_rr !== MW'(k % N) || g_rr !== (N'(1) << (k % N)) || l_rr !== 1'b1) begin
                n_bad++;
                $display("FAIL rr_single k=%0d got m=%0d g=%b l=%b want m=%0d l=1", k, m_rr, g_rr, l_rr, k % N);
            end
            n_cmp++;
            if (m_fx !== MW'(0) || g_fx !== 4'b0001 || l_fx !== 1'b1) begin
                n_bad++;
                $display("FAIL fx_single k=%0d got m=%0d g=%b l=%b want m=0 g=0001 l=1", k, m_fx, g_fx, l_fx);
            end
            tick();
        end
        hreq = '0;
        tick();
    endtask

    task automatic test_incr8_stall();
        int         held = 0;
        logic [9:0] stall = 10'b0000100100;
        idle_reset();
        hreq         = 4'b0100;
        hburst       = BW'($urandom);
        hburst[8:6]  = 3'd5;
        tick();
        hreq = '0;
        for (int i = 0; i < 10; i++) begin
            hwait  = stall[i];
            hburst = BW'($urandom);
            @(negedge hclk);
            if (g_rr == 4'b0100 && g_fx == 4'b0100) held++;
            n_cmp++;
            if (l_rr !== (i == 9) || l_fx !== (i == 9)) begin
                n_bad++;
                $display("FAIL incr8_last cyc=%0d got rr=%b fx=%b want %0d", i, l_rr, l_fx, (i == 9));
            end
            tick();
        end
        hwait = 1'b0;
        @(negedge hclk);
        n_cmp++;
        if (held != 10 || g_rr !== '0 || g_fx !== '0) begin
            n_bad++;
            $display("FAIL incr8_hold got held=%0d rr=%b fx=%b want held=10 grant 0000", held, g_rr, g_fx);
        end
    endtask

    task automatic test_fixed_preempt();
        idle_reset();
        hreq          = 4'b1000;
        hburst        = '0;
        hburst[11:9]  = 3'd2;
        tick();
        hreq = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            n_cmp++;
            if (m_fx !== MW'(3) || g_fx !== 4'b1000 || l_fx !== (i == 3)) begin
                n_bad++;
                $display("FAIL wrap4_owner beat=%0d got m=%0d g=%b l=%b want m=3 l=%0d", i + 1, m_fx, g_fx, l_fx, (i == 3));
            end
            tick();
        end
        @(negedge hclk);
        n_cmp++;
        if (g_fx !== 4'b0001 || g_rr !== 4'b0001) begin
            n_bad++;
            $display("FAIL wrap4_handover got fx=%b rr=%b want 0001", g_fx, g_rr);
        end
        hreq = '0;
        tick();
        tick();
    endtask

    task automatic test_incr();
        idle_reset();
        hreq        = 4'b0010;
        hburst      = '0;
        hburst[5:3] = 3'd1;
        tick();
        for (int b = 1; b <= IMB; b++) begin
            @(negedge hclk);
            n_cmp++;
            if (g_rr !== 4'b0010 || l_rr !== (b == IMB) || l_fx !== (b == IMB)) begin
                n_bad++;
                $display("FAIL incr_forced beat=%0d got g=%b l_rr=%b l_fx=%b want l=%0d", b, g_rr, l_rr, l_fx, (b == IMB));
            end
            tick();
        end
        for (int b = 1; b <= 5; b++) begin
            if (b == 5) hreq = '0;
            @(negedge hclk);
            n_cmp++;
            if (g_fx !== 4'b0010 || l_rr !== (b == 5) || l_fx !== (b == 5)) begin
                n_bad++;
                $display("FAIL incr_drop beat=%0d got g=%b l_rr=%b l_fx=%b want l=%0d", b, g_fx, l_rr, l_fx, (b == 5));
            end
            tick();
        end
        @(negedge hclk);
        n_cmp++;
        if (g_rr !== '0 || g_fx !== '0) begin
            n_bad++;
            $display("FAIL incr_release got rr=%b fx=%b want 0000", g_rr, g_fx);
        end
    endtask

    task automatic test_reset_mid();
        idle_reset();
        hreq        = 4'b0001;
        hburst      = '0;
        hburst[2:0] = 3'd7;
        tick();
        tick();
        hreset = 1'b1;
        tick();
        @(negedge hclk);
        n_cmp++;
        if (g_rr !== '0 || s_rr !== 1'b0 || m_rr !== '0 || g_fx !== '0 || s_fx !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_abort got rr g=%b s=%b m=%0d fx g=%b s=%b want idle", g_rr, s_rr, m_rr, g_fx, s_fx);
        end
        hreset      = 1'b0;
        hreq        = 4'b0100;
        hburst[8:6] = 3'd0;
        tick();
        @(negedge hclk);
        n_cmp++;
        if (g_rr !== 4'b0100 || g_fx !== 4'b0100 || m_rr !== MW'(2)) begin
            n_bad++;
            $display("FAIL rst_regrant got rr=%b/%0d fx=%b want 0100/2", g_rr, m_rr, g_fx);
        end
        hreset = 1'b1;
        #1;
        n_cmp++;
        if (l_rr !== 1'b0 || l_fx !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_hlast got rr=%b fx=%b want 0", l_rr, l_fx);
        end
        tick();
        hreset = 1'b0;
        hreq   = '1;
        hburst = '0;
        tick();
        @(negedge hclk);
        n_cmp++;
        if (g_rr !== 4'b0001 || m_rr !== MW'(0)) begin
            n_bad++;
            $display("FAIL rst_pointer got rr=%b/%0d want 0001/0", g_rr, m_rr);
        end
        hreq = '0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            hreset = ($urandom_range(0, 63) == 0);
            hreq   = N'($urandom);
            if ($urandom_range(0, 3) == 0) hreq = '0;
            hburst = BW'($urandom);
            hwait  = ($urandom_range(0, 2) == 0);
            @(negedge hclk);
            model_outputs();
            n_cmp++;
            if (g_rr !== e_grant[1] || m_rr !== MW'(e_master[1]) || s_rr !== e_sel[1] || l_rr !== e_last[1]) begin
                n_bad++;
                $display("FAIL rand_rr cyc=%0d got g=%b m=%0d s=%b l=%b want g=%b m=%0d s=%b l=%b",
                         c, g_rr, m_rr, s_rr, l_rr, e_grant[1], e_master[1], e_sel[1], e_last[1]);
            end
            n_cmp++;
            if (g_fx !== e_grant[0] || m_fx !== MW'(e_master[0]) || s_fx !== e_sel[0] || l_fx !== e_last[0]) begin
                n_bad++;
                $display("FAIL rand_fx cyc=%0d got g=%b m=%0d s=%b l=%b want g=%b m=%0d s=%b l=%b",
                         c, g_fx, m_fx, s_fx, l_fx, e_grant[0], e_master[0], e_sel[0], e_last[0]);
            end
            n_cmp++;
            if (!$onehot0(g_rr) || !$onehot0(g_fx)) begin
                n_bad++;
                $display("FAIL rand_onehot cyc=%0d got rr=%b fx=%b want at most one bit", c, g_rr, g_fx);
            end
            tick();
        end
        hreset = 1'b0;
        hreq   = '0;
        hwait  = 1'b0;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            md_owner[m] = -1;
            md_beats[m] = 0;
            md_len[m]   = 1;
            md_incr[m]  = 0;
            md_ptr[m]   = 0;
        end
        test_reset();
        test_rr_singles();
        test_incr8_stall();
        test_fixed_preempt();
        test_incr();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
